// File: rtl/conv_core_pkg.sv
// Shared types and constants for the conv_core_n convolution engine.
package conv_core_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    typedef enum logic {
        MODE_FULL  = 1'b0,
        MODE_VALID = 1'b1
    } mode_t;

    // Cycles between the last MAC strobe and the write; covers capture and product stages.
    localparam int unsigned DRAIN_LEN = 2;

    function automatic int unsigned conv_len(input mode_t m, input int unsigned nx, input int unsigned ny);
        return (m == MODE_VALID) ? (nx - ny + 1) : (nx + ny - 1);
    endfunction

endpackage

// File: rtl/conv_mac_pipe.sv
// MAC datapath: capture -> product -> accumulator, result of acc plus in-flight product; CONV_SAT_EN selects clip vs truncate.
// Latency: strobe to accumulator 3 cycles; res already includes the product still in the product stage.
// Backpressure: stall freezes product/acc; one read returning during a stall is parked in a skid slot.
module conv_mac_pipe
#(
    parameter int DW    = 32,
    parameter int OW    = 32,
    parameter int ACC_W = 69
)
(
    input  logic          clk,
    input  logic          rst_a,
    input  logic          stall,
    input  logic          clr,
    input  logic          issue,
    input  logic [DW-1:0] x_data,
    input  logic [DW-1:0] y_data,
    output logic [OW-1:0] res,
    output logic          clip
);
    localparam int PW = 2 * DW;

    logic             rd_q, rd_d;
    logic             cap_vld_q, cap_vld_d, sk_vld_q, sk_vld_d, prod_vld_q, prod_vld_d;
    logic [DW-1:0]    cap_x_q, cap_x_d, cap_y_q, cap_y_d, sk_x_q, sk_x_d, sk_y_q, sk_y_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum;

    assign sum = acc_q + ACC_W'(prod_vld_q ? prod_q : '0);

    always_comb begin
        rd_d       = issue;
        cap_vld_d  = cap_vld_q;
        cap_x_d    = cap_x_q;
        cap_y_d    = cap_y_q;
        sk_vld_d   = sk_vld_q;
        sk_x_d     = sk_x_q;
        sk_y_d     = sk_y_q;
        prod_vld_d = prod_vld_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        if (!stall) begin
            if (sk_vld_q) begin
                cap_vld_d = 1'b1;
                cap_x_d   = sk_x_q;
                cap_y_d   = sk_y_q;
                sk_vld_d  = 1'b0;
            end else begin
                cap_vld_d = rd_q;
                if (rd_q) begin
                    cap_x_d = x_data;
                    cap_y_d = y_data;
                end
            end
            prod_vld_d = cap_vld_q;
            if (cap_vld_q) prod_d = PW'(cap_x_q) * PW'(cap_y_q);
            acc_d = clr ? '0 : sum;
        end else if (rd_q) begin
            // Memory data is only valid for one cycle; park it until the stage frees up.
            sk_vld_d = 1'b1;
            sk_x_d   = x_data;
            sk_y_d   = y_data;
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            rd_q       <= 1'b0;
            cap_vld_q  <= 1'b0;
            cap_x_q    <= '0;
            cap_y_q    <= '0;
            sk_vld_q   <= 1'b0;
            sk_x_q     <= '0;
            sk_y_q     <= '0;
            prod_vld_q <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
        end else begin
            rd_q       <= rd_d;
            cap_vld_q  <= cap_vld_d;
            cap_x_q    <= cap_x_d;
            cap_y_q    <= cap_y_d;
            sk_vld_q   <= sk_vld_d;
            sk_x_q     <= sk_x_d;
            sk_y_q     <= sk_y_d;
            prod_vld_q <= prod_vld_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
        end
    end

`ifdef CONV_SAT_EN
    assign clip = |sum[ACC_W-1:OW];
    assign res  = clip ? {OW{1'b1}} : sum[OW-1:0];
`else
    assign clip = 1'b0;
    assign res  = sum[OW-1:0];
`endif

endmodule

// File: rtl/conv_core_n.sv
// 1-D full/valid convolution engine over external X/Y/Z memories; CONV_SAT_EN enables result clipping and ovf.
// Latency: sum over outputs of (terms + 4) cycles from accept to done.
// Backpressure: en_s=0 freezes the run and masks all strobes; start is ignored while busy.
module conv_core_n
    import conv_core_pkg::*;
#(
    parameter int DW    = 32,
    parameter int OW    = 32,
    parameter int AW_X  = 5,
    parameter int AW_Y  = 5,
    parameter int AW_Z  = 6,
    parameter int ACC_W = 2 * DW + AW_Y
)
(
    input  logic            clk,
    input  logic            rst_a,
    input  logic            en_s,
    input  logic            start,
    input  logic            mode,
    input  logic [AW_X:0]   size_x,
    input  logic [AW_Y:0]   size_y,
    output logic            x_rd,
    output logic [AW_X-1:0] x_addr,
    input  logic [DW-1:0]   x_data,
    output logic            y_rd,
    output logic [AW_Y-1:0] y_addr,
    input  logic [DW-1:0]   y_data,
    output logic            z_wr,
    output logic [AW_Z-1:0] z_addr,
    output logic [OW-1:0]   z_data,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            ovf
);
    localparam int AMX = (AW_X > AW_Y) ? AW_X : AW_Y;
    localparam int AM  = (AMX > AW_Z) ? AMX : AW_Z;
    localparam int IW  = AM + 2;

    state_t          state_q, state_d;
    mode_t           mode_q, mode_d;
    logic [IW-1:0]   nx_q, nx_d, ny_q, ny_d, len_q, len_d, n_q, n_d, k_q, k_d, khi_q, khi_d;
    logic [1:0]      dr_q, dr_d;
    logic            err_q, err_d;
    logic [IW-1:0]   off_w, m_w, klo_w, khi_w;
    logic [31:0]     nx_w, ny_w, len_w;
    logic            bad, accept, clr, issue, clip;
    logic [OW-1:0]   res;

    assign nx_w  = 32'(size_x);
    assign ny_w  = 32'(size_y);
    assign len_w = conv_len(mode_t'(mode), nx_w, ny_w);
    assign bad   = (nx_w == 32'd0) || (ny_w == 32'd0) || (nx_w > (32'd1 << AW_X)) ||
                   (ny_w > (32'd1 << AW_Y)) || (mode && (ny_w > nx_w)) || (len_w > (32'd1 << AW_Z));
    assign accept = (state_q == S_IDLE) && start && en_s && !bad;

    // m = n + O; the k window is clipped to the span where both operands exist.
    assign off_w = (mode_q == MODE_VALID) ? ny_q - IW'(1) : '0;
    assign m_w   = n_q + off_w;
    assign klo_w = (m_w + IW'(1) > nx_q) ? m_w + IW'(1) - nx_q : '0;
    assign khi_w = (m_w < ny_q - IW'(1)) ? m_w : ny_q - IW'(1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        len_d   = len_q;
        n_d     = n_q;
        k_d     = k_q;
        khi_d   = khi_q;
        dr_d    = dr_q;
        err_d   = 1'b0;
        clr     = 1'b0;
        issue   = en_s && (state_q == S_MAC);
        x_rd    = issue;
        y_rd    = issue;
        x_addr  = issue ? AW_X'(m_w - k_q) : '0;
        y_addr  = issue ? AW_Y'(k_q) : '0;
        z_wr    = en_s && (state_q == S_WRITE);
        z_addr  = (state_q == S_WRITE) ? AW_Z'(n_q) : '0;
        z_data  = (state_q == S_WRITE) ? res : '0;
        busy    = (state_q != S_IDLE) && (state_q != S_DONE);
        done    = (state_q == S_DONE);
        if (en_s) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && bad) err_d = 1'b1;
                    if (accept) begin
                        state_d = S_SETUP;
                        mode_d  = mode_t'(mode);
                        nx_d    = IW'(nx_w);
                        ny_d    = IW'(ny_w);
                        len_d   = IW'(len_w);
                        n_d     = '0;
                    end
                end
                S_SETUP: begin
                    k_d     = klo_w;
                    khi_d   = khi_w;
                    clr     = 1'b1;
                    state_d = S_MAC;
                end
                S_MAC: begin
                    if (k_q == khi_q) begin
                        dr_d    = '0;
                        state_d = S_DRAIN;
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
                S_DRAIN: begin
                    if (dr_q == 2'(DRAIN_LEN - 1)) state_d = S_WRITE;
                    else                          dr_d    = dr_q + 2'd1;
                end
                S_WRITE: begin
                    if (n_q == len_q - IW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_q + IW'(1);
                        state_d = S_SETUP;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_FULL;
            nx_q    <= '0;
            ny_q    <= '0;
            len_q   <= '0;
            n_q     <= '0;
            k_q     <= '0;
            khi_q   <= '0;
            dr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            len_q   <= len_d;
            n_q     <= n_d;
            k_q     <= k_d;
            khi_q   <= khi_d;
            dr_q    <= dr_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

    conv_mac_pipe #(.DW(DW), .OW(OW), .ACC_W(ACC_W)) u_mac (
        .clk    (clk),
        .rst_a  (rst_a),
        .stall  (!en_s),
        .clr    (clr),
        .issue  (issue),
        .x_data (x_data),
        .y_data (y_data),
        .res    (res),
        .clip   (clip)
    );

`ifdef CONV_SAT_EN
    logic sat_q, sat_d;

    always_comb begin
        sat_d = sat_q;
        if (accept)                                   sat_d = 1'b0;
        else if (en_s && (state_q == S_WRITE) && clip) sat_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) sat_q <= 1'b0;
        else        sat_q <= sat_d;
    end

    assign ovf = (state_q == S_DONE) && sat_q;
`else
    logic unused_clip;
    assign unused_clip = clip;
    assign ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_conv_core_n.sv
// Directed bench for conv_core_n: full/valid runs, config rejects, stall, saturation and mid-run reset.
module tb_conv_core_n;
    logic        clk = 1'b0;
    logic        rst_a, en_s, start, mode;
    logic [5:0]  size_x, size_y;
    logic        x_rd, y_rd, z_wr, busy, done, err, ovf;
    logic [4:0]  x_addr, y_addr;
    logic [5:0]  z_addr;
    logic [31:0] x_data = '0, y_data = '0, z_data;
    logic [31:0] xmem [32];
    logic [31:0] ymem [32];
    logic [31:0] zmem [64];
    logic        zclr = 1'b0;
    logic [54:0] outs;
    int          cyc = 0, wr_cnt = 0, rd_cnt = 0;
    int          pass_cnt = 0, total = 0;
    int          e0, lat, busy_bad, wrb, rdb, bad_n;
    logic        ovf_seen;

    always #5 clk = ~clk;

    conv_core_n #(.DW(32), .OW(32), .AW_X(5), .AW_Y(5), .AW_Z(6)) dut (
        .clk(clk), .rst_a(rst_a), .en_s(en_s), .start(start), .mode(mode),
        .size_x(size_x), .size_y(size_y),
        .x_rd(x_rd), .x_addr(x_addr), .x_data(x_data),
        .y_rd(y_rd), .y_addr(y_addr), .y_data(y_data),
        .z_wr(z_wr), .z_addr(z_addr), .z_data(z_data),
        .busy(busy), .done(done), .err(err), .ovf(ovf)
    );

    assign outs = {x_rd, x_addr, y_rd, y_addr, z_wr, z_addr, z_data, busy, done, err, ovf};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (x_rd) x_data <= xmem[x_addr];
        if (y_rd) y_data <= ymem[y_addr];
        if (x_rd || y_rd) rd_cnt <= rd_cnt + 1;
        if (z_wr) wr_cnt <= wr_cnt + 1;
        if (zclr) begin
            for (int i = 0; i < 64; i++) zmem[i] <= 32'hDEADBEEF;
        end else if (z_wr) begin
            zmem[z_addr] <= z_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model(input logic md, input int nx, input int ny, input int n);
        longint unsigned s = 0;
        int m = n + (md ? ny - 1 : 0);
        for (int k = 0; k < ny; k++)
            if (m - k >= 0 && m - k < nx) s += longint'(xmem[m-k]) * longint'(ymem[k]);
        return s[31:0];
    endfunction

    task automatic zclear();
        @(negedge clk); zclr = 1'b1;
        @(negedge clk); zclr = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic md, input int nx, input int ny);
        int len = md ? nx - ny + 1 : nx + ny - 1;
        bad_n = 0;
        for (int n = 0; n < len; n++) if (zmem[n] !== model(md, nx, ny, n)) bad_n++;
        chk(tag, 64'(bad_n), 64'(0));
    endtask

    // Launch a run, optionally drop en_s for 3 cycles starting stall_at cycles after accept.
    task automatic run(input logic md, input int nx, input int ny, input int stall_at);
        @(negedge clk);
        start = 1'b1; mode = md; size_x = 6'(nx); size_y = 6'(ny);
        wrb = wr_cnt;
        @(negedge clk);
        e0 = cyc; start = 1'b0;
        mode = ~md; size_x = 6'd3; size_y = 6'd1;
        lat = -1; busy_bad = 0; ovf_seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                lat = cyc - e0; ovf_seen = ovf;
                if (err) busy_bad++;
                break;
            end
            if (!busy || err || ovf) busy_bad++;
            if (stall_at != 0) en_s = !((cyc - e0) >= stall_at && (cyc - e0) < stall_at + 3);
            @(negedge clk);
        end
        en_s = 1'b1;
        @(negedge clk);
        chk("post_done_idle", 64'({done, busy, ovf}), 64'(0));
    endtask

    initial begin
        rst_a = 1'b0; en_s = 1'b1; start = 1'b0; mode = 1'b0; size_x = '0; size_y = '0;
        for (int i = 0; i < 32; i++) begin
            xmem[i] = (i < 10) ? 32'(i + 1) : 32'd0;
            ymem[i] = (i < 5) ? 32'(i + 1) : 32'd0;
        end
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'(outs), 64'(0));
        rst_a = 1'b1;
        zclear();

        // Full mode NX=10 NY=5
        run(1'b0, 10, 5, 0);
        chk("full_wr_cnt", 64'(wr_cnt - wrb), 64'(14));
        chk("full_z0", 64'(zmem[0]), 64'(1));
        chk("full_z1", 64'(zmem[1]), 64'(4));
        chk("full_z4", 64'(zmem[4]), 64'(35));
        chk("full_z13", 64'(zmem[13]), 64'(50));
        check_all("full_all", 1'b0, 10, 5);
        chk("full_latency", 64'(lat), 64'(106));
        chk("full_busy", 64'(busy_bad), 64'(0));
        chk("full_ovf", 64'(ovf_seen), 64'(0));

        // Valid mode, same data
        zclear();
        run(1'b1, 10, 5, 0);
        chk("valid_wr_cnt", 64'(wr_cnt - wrb), 64'(6));
        chk("valid_z0", 64'(zmem[0]), 64'(35));
        chk("valid_z5", 64'(zmem[5]), 64'(110));
        chk("valid_latency", 64'(lat), 64'(54));

        // Rejected configs
        @(negedge clk);
        start = 1'b1; mode = 1'b1; size_x = 6'd3; size_y = 6'd5; rdb = rd_cnt;
        @(negedge clk);
        start = 1'b0;
        chk("rej_ny_gt_nx_err", 64'({err, busy}), 64'(2));
        @(negedge clk);
        chk("rej_ny_gt_nx_clear", 64'({err, busy, done}), 64'(0));
        chk("rej_no_strobes", 64'(rd_cnt - rdb), 64'(0));
        start = 1'b1; mode = 1'b1; size_x = 6'd0; size_y = 6'd5;
        @(negedge clk);
        start = 1'b0;
        chk("rej_nx0_err", 64'({err, busy}), 64'(2));
        start = 1'b1; mode = 1'b0; size_x = 6'd33; size_y = 6'd1;
        @(negedge clk);
        start = 1'b0;
        chk("rej_nx_big_err", 64'({err, busy}), 64'(2));

        // Stall of 3 cycles inside the n=4 MAC burst
        zclear();
        run(1'b0, 10, 5, 29);
        check_all("stall_all", 1'b0, 10, 5);
        chk("stall_wr_cnt", 64'(wr_cnt - wrb), 64'(14));
        chk("stall_latency", 64'(lat), 64'(109));

        // All-ones operands, NX=NY=2
        for (int i = 0; i < 2; i++) begin
            xmem[i] = 32'hFFFFFFFF; ymem[i] = 32'hFFFFFFFF;
        end
        zclear();
        run(1'b0, 2, 2, 0);
`ifdef CONV_SAT_EN
        chk("sat_z0", 64'(zmem[0]), 64'(32'hFFFFFFFF));
        chk("sat_z1", 64'(zmem[1]), 64'(32'hFFFFFFFF));
        chk("sat_z2", 64'(zmem[2]), 64'(32'hFFFFFFFF));
        chk("sat_ovf", 64'(ovf_seen), 64'(1));
`else
        chk("trunc_z0", 64'(zmem[0]), 64'(1));
        chk("trunc_z1", 64'(zmem[1]), 64'(2));
        chk("trunc_z2", 64'(zmem[2]), 64'(1));
        chk("trunc_ovf", 64'(ovf_seen), 64'(0));
`endif
        chk("ones_latency", 64'(lat), 64'(16));
        for (int i = 0; i < 2; i++) begin
            xmem[i] = 32'(i + 1); ymem[i] = 32'(i + 1);
        end

        // Reset asserted during the WRITE of n=3
        zclear();
        @(negedge clk);
        start = 1'b1; mode = 1'b0; size_x = 6'd10; size_y = 6'd5; wrb = wr_cnt;
        @(negedge clk);
        e0 = cyc; start = 1'b0;
        for (int i = 0; i < 200 && (cyc - e0) < 25; i++) @(negedge clk);
        chk("rst_at_write_n3", 64'({z_wr, z_addr}), 64'({1'b1, 6'd3}));
        rst_a = 1'b0;
        #1;
        chk("rst_mid_outs", 64'(outs), 64'(0));
        repeat (2) @(negedge clk);
        chk("rst_hold_outs", 64'(outs), 64'(0));
        chk("rst_wr_cnt", 64'(wr_cnt - wrb), 64'(3));
        rst_a = 1'b1;
        @(negedge clk);
        chk("rst_release_idle", 64'(outs), 64'(0));
        zclear();
        run(1'b0, 10, 5, 0);
        check_all("after_rst_all", 1'b0, 10, 5);
        chk("after_rst_wr_cnt", 64'(wr_cnt - wrb), 64'(14));
        chk("after_rst_latency", 64'(lat), 64'(106));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/conv_core_n.md
# conv_core_n

Parametrised 1-D discrete convolution engine, the next generation of the fixed-size convolution AIP datapath. It computes z = x * y in full mode (NX+NY−1 outputs) or valid mode (NX−NY+1 outputs). Operands come from external synchronous-read X/Y memories and results go to an external Z memory. It sits behind the AIP register/memory wrapper, which supplies sizes and mode from the config register and maps done to the status/interrupt logic.

## Interface
- DW, 32, operand width (unsigned)
- OW, 32, result word width written to Z
- AW_X, 5, X memory address width (depth 2^AW_X)
- AW_Y, 5, Y memory address width
- AW_Z, 6, Z memory address width
- ACC_W, 2*DW+AW_Y, accumulator width
- clk  in  1  clock; all logic on rising edge
- rst_a  in  1  asynchronous, active-low reset
- en_s  in  1  synchronous enable; 0 stalls the engine
- start  in  1  start request, sampled when idle
- mode  in  1  0 = full, 1 = valid
- size_x  in  AW_X+1  NX, legal 1..2^AW_X
- size_y  in  AW_Y+1  NY, legal 1..2^AW_Y
- x_rd, x_addr  out  1, AW_X  X read strobe/address
- x_data  in  DW  X read data, valid 1 cycle after x_rd
- y_rd, y_addr  out  1, AW_Y  Y read strobe/address
- y_data  in  DW  Y read data, valid 1 cycle after y_rd
- z_wr, z_addr, z_data  out  1, AW_Z, OW  Z write port
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, run complete
- err  out  1  one-cycle pulse, config rejected
- ovf  out  1  valid with done; any result saturated

## Operation
- Start is accepted when IDLE and start=1 and en_s=1. On accept, mode, NX and NY are latched.
- Config check on accept. Reject if NX=0, NY=0, NX>2^AW_X, NY>2^AW_Y, mode=1 with NY>NX, or LEN>2^AW_Z. On reject: err pulses next cycle, busy stays 0, state stays IDLE.
- LEN = NX+NY−1 (full) or NX−NY+1 (valid). O = 0 (full) or NY−1 (valid).
- For n = 0..LEN−1: m = n+O; z[n] = Σ x[m−k]·y[k] for k = max(0, m−NX+1) .. min(m, NY−1). Terms T_n = k_hi−k_lo+1.
- FSM states:
  - IDLE → SETUP on accept.
  - SETUP (1 cycle): compute k_lo and k_hi, clear the accumulator.
  - MAC (T_n cycles): one x_rd+y_rd per cycle, k ascending, x_addr = m−k, y_addr = k.
  - DRAIN (2 cycles).
  - WRITE (1 cycle): z_wr=1, z_addr=n, z_data = result. Then n=LEN−1 → DONE, else SETUP.
  - DONE (1 cycle): done=1, busy drops in the same cycle → IDLE.
- MAC pipeline: capture register (x_data, y_data, valid) → product register (2·DW) → accumulator (ACC_W). Arithmetic is unsigned; the accumulator never wraps at legal sizes.
- start while busy is ignored. mode and size changes during a run have no effect.

## Timing
- Reset values: all outputs 0, state IDLE, n=0, accumulator 0.
- Reset asserted mid-run aborts immediately. No done and no further writes.
- Run length from the accept edge E0: Σ(T_n+4) cycles, then done is high in the following cycle. Full mode NX=10, NY=5: done registered at E0+106. Valid mode, same sizes: done at E0+54.
- en_s=0 freezes the FSM, product register and accumulator, and forces x_rd/y_rd/z_wr to 0.
- The capture register still loads on the cycle after a strobe, so data returning during a stall is held, not lost. Resuming continues exactly where the run stopped.
- done and err are never asserted together. ovf is meaningful only in the done cycle and 0 otherwise.

## Configuration
- CONV_SAT_EN defined:
  - In WRITE, an accumulator value ≥ 2^OW is clipped to 2^OW−1.
  - A sticky flag records any clip during the run; it is presented on ovf with done and cleared on the next accept.
- CONV_SAT_EN undefined: z_data = acc[OW−1:0] (truncation) and ovf is tied 0.

## Structure
- Package conv_core_pkg holds:
  - state enum (S_IDLE, S_SETUP, S_MAC, S_DRAIN, S_WRITE, S_DONE)
  - mode enum (MODE_FULL, MODE_VALID)
  - a constant function for LEN
  - the DRAIN length constant (2)
- One sub-module, conv_mac_pipe: capture, multiply, accumulate and the saturation/truncation output stage, with a clear input and a stall input.

## Test plan
- Full mode, NX=10 NY=5, x=1..10, y=1..5, memories with 1-cycle latency → 14 writes: z[0]=1, z[1]=4, z[4]=35, z[13]=50. Done at E0+106, busy 1 throughout.
- Valid mode, same data → 6 writes: z[0]=35, z[5]=110. Done at E0+54.
- Valid mode, NX=3 NY=5 → err pulse one cycle after start, no strobes, busy 0. The same start with size_x=0 → err.
- en_s low for 3 cycles in the middle of a MAC burst (full, NX=10 NY=5) → identical z values; done at E0+109.
- DW=OW=32, NX=NY=2, all operands 0xFFFFFFFF:
  - With CONV_SAT_EN: z[0..2] = 0xFFFFFFFF, ovf=1.
  - Without it: z[0]=0x00000001, z[1]=0x00000002, z[2]=0x00000001, ovf=0.
- rst_a low during WRITE of n=3 → all outputs 0 within the reset. A new start then runs a full, correct computation from n=0.
